dice_game_ctrl: RTL

Sequences the shared die-roll unit (btn/enable/num/choose interface) to play a full craps game. Each throw is two rolls of the same unit: die A, then die B. The block sums the throw, applies come-out and point rules, and holds a win/lose result until the next game. It sits between the board-level start input and the roll unit, and drives the result/score displays.

---
 rtl/dice_game_ctrl_pkg.sv | 15 +
 rtl/dice_game_ctrl_if.sv | 8 +
 rtl/dice_game_ctrl_eval.sv | 15 +
 rtl/dice_game_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/dice_game_ctrl_pkg.sv
// dice_pkg: shared FSM states, throw outcomes and craps constants for dice_game_ctrl.
package dice_pkg;
    typedef enum logic [2:0] {IDLE, ROLL_A, GAP_AB, ROLL_B, EVAL, GAP_NEXT, DONE} dice_state_t;
    typedef enum logic [1:0] {OUT_CONT, OUT_WIN, OUT_LOSE} dice_outcome_t;
    localparam logic [3:0] SUM_SEVEN = 4'd7;
    localparam logic [3:0] SUM_YO    = 4'd11;
    localparam logic [3:0] CRAPS_2   = 4'd2;
    localparam logic [3:0] CRAPS_3   = 4'd3;
    localparam logic [3:0] CRAPS_12  = 4'd12;
    localparam logic [2:0] DIE_MIN   = 3'd1;
    localparam logic [2:0] DIE_MAX   = 3'd6;
    function automatic logic die_valid(input logic [2:0] n);
        return n >= DIE_MIN && n <= DIE_MAX;
    endfunction
endpackage

// File: rtl/dice_game_ctrl_if.sv
// dice_game_ctrl_if: enable/num/choose link between the game controller and the shared roll unit.
interface dice_game_ctrl_if;
    logic       roll_enable;
    logic [2:0] roll_num;
    logic       roll_choose;
    modport master (output roll_enable, input roll_num, input roll_choose);
    modport slave  (input roll_enable, output roll_num, output roll_choose);
endinterface

// File: rtl/dice_game_ctrl_eval.sv
// dice_eval: combinational craps rule check of a throw sum against the current point (0 = come-out).
module dice_eval
    import dice_pkg::*;
(
    input  logic [3:0]    sum,
    input  logic [3:0]    point,
    output dice_outcome_t outcome
);
    logic come_win, come_lose;
    assign come_win  = sum == SUM_SEVEN || sum == SUM_YO;
    assign come_lose = sum == CRAPS_2 || sum == CRAPS_3 || sum == CRAPS_12;
    assign outcome = point == 4'd0
        ? (come_win ? OUT_WIN : come_lose ? OUT_LOSE : OUT_CONT)
        : (sum == point ? OUT_WIN : sum == SUM_SEVEN ? OUT_LOSE : OUT_CONT);
endmodule

// File: rtl/dice_game_ctrl.sv
// dice_game_ctrl: plays a craps game by sequencing two rolls per throw on the shared roll unit.
// Optional DICE_TALLY_EN adds saturating win/loss counters.
module dice_game_ctrl
    import dice_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    dice_game_ctrl_if.master        roll,
    output logic [2:0]              die_a,
    output logic [2:0]              die_b,
    output logic [3:0]              sum,
    output logic [3:0]              point,
    output logic                    busy,
    output logic                    win,
    output logic                    lose,
    output logic [7:0]              wins,
    output logic [7:0]              losses
);
    localparam int CW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("GAP_CYCLES must be >= 1");
    end

    dice_state_t   state;
    logic [CW-1:0] cnt;
    logic          choose_ok;
    dice_outcome_t outcome;

    assign choose_ok = roll.roll_choose && die_valid(roll.roll_num);

    dice_eval u_eval (.sum(sum), .point(point), .outcome(outcome));

    // Outputs are registered alongside the state so enable is glitch-free at the roll unit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            roll.roll_enable <= 1'b0;
            die_a            <= '0;
            die_b            <= '0;
            sum              <= '0;
            point            <= '0;
            busy             <= 1'b0;
            win              <= 1'b0;
            lose             <= 1'b0;
`ifdef DICE_TALLY_EN
            wins             <= '0;
            losses           <= '0;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: if (start) begin
                    die_a            <= '0;
                    die_b            <= '0;
                    sum              <= '0;
                    point            <= '0;
                    win              <= 1'b0;
                    lose             <= 1'b0;
                    busy             <= 1'b1;
                    roll.roll_enable <= 1'b1;
                    state            <= ROLL_A;
                end
                ROLL_A: if (choose_ok) begin
                    die_a            <= roll.roll_num;
                    roll.roll_enable <= 1'b0;
                    cnt              <= GAP_LOAD;
                    state            <= GAP_AB;
                end
                GAP_AB: if (cnt == '0) begin
                    roll.roll_enable <= 1'b1;
                    state            <= ROLL_B;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                ROLL_B: if (choose_ok) begin
                    die_b            <= roll.roll_num;
                    sum              <= {1'b0, die_a} + {1'b0, roll.roll_num};
                    roll.roll_enable <= 1'b0;
                    state            <= EVAL;
                end
                EVAL: if (outcome == OUT_WIN) begin
                    win   <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
`ifdef DICE_TALLY_EN
                    wins  <= wins + {7'd0, wins != 8'hFF};
`endif
                end else if (outcome == OUT_LOSE) begin
                    lose   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= DONE;
`ifdef DICE_TALLY_EN
                    losses <= losses + {7'd0, losses != 8'hFF};
`endif
                end else begin
                    point <= point == 4'd0 ? sum : point;
                    cnt   <= GAP_LOAD;
                    state <= GAP_NEXT;
                end
                GAP_NEXT: if (cnt == '0) begin
                    roll.roll_enable <= 1'b1;
                    state            <= ROLL_A;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                default: begin
                    roll.roll_enable <= 1'b0;
                    busy             <= 1'b0;
                    state            <= IDLE;
                end
            endcase
        end
    end

`ifndef DICE_TALLY_EN
    assign wins   = '0;
    assign losses = '0;
`endif
endmodule
